// File: rtl/axi_rd_sram_responder.sv
// rtl/axi_rd_sram_responder.sv - AXI4 read-only AR/R responder over a 1-cycle-latency SRAM.
// Optional per-beat address range check enabled by defining AXI_RD_RANGECHK_EN.
module axi_rd_sram_responder #(
  parameter int              DW        = 64,
  parameter int              AW        = 32,
  parameter int              IDW       = 8,
  parameter int              MEM_AW    = 12,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [AW-1:0]     s_araddr,
  input  logic [IDW-1:0]    s_arid,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DW-1:0]     s_rdata,
  output logic [IDW-1:0]    s_rid,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              mem_ren,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int LSB = $clog2(DW / 8);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic            err_q, err_d;
  logic            infl_q, infl_d;
  logic            infl_err_q, infl_err_d;
  logic            infl_last_q, infl_last_d;
  logic [DW+2:0]   slot0_q, slot0_d;
  logic [DW+2:0]   slot1_q, slot1_d;
  logic [1:0]      nbuf_q, nbuf_d;

  logic [AW-1:0]   off, step, wmask, addr_inc, addr_next;
  logic            range_err, beat_err, issue, ar_hs, ar_err, wrap_ok;
  logic            pop, pop_buf, push;
  logic [DW-1:0]   in_data;
  logic [DW+2:0]   in_entry, head;

  assign s_arready = (state_q == IDLE) && !arst_i;
  assign ar_hs     = s_arvalid && s_arready;
  assign wrap_ok   = (s_arlen == 8'd1) || (s_arlen == 8'd3) || (s_arlen == 8'd7) || (s_arlen == 8'd15);
  assign ar_err    = (s_arsize > 3'(LSB)) || (s_arburst == 2'b11) || ((s_arburst == 2'b10) && !wrap_ok);

  always_comb begin
    off      = addr_q - BASE_ADDR;
    step     = AW'(1) << size_q;
    wmask    = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    addr_inc = addr_q + step;
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wmask) | (addr_inc & wmask);
      default: addr_next = addr_inc;
    endcase
`ifdef AXI_RD_RANGECHK_EN
    range_err = (addr_q < BASE_ADDR) || ((off >> (MEM_AW + LSB)) != '0);
`else
    range_err = 1'b0;
`endif
    beat_err = err_q || range_err;
    // A read may be issued only while its result is guaranteed a FIFO slot.
    issue    = (state_q == BURST) && ((nbuf_q + {1'b0, infl_q}) < 2'd2);
    mem_ren  = issue && !beat_err;
    mem_addr = MEM_AW'(off >> LSB);
  end

  always_comb begin
    in_data  = infl_err_q ? '0 : mem_rdata;
    in_entry = {in_data, (infl_err_q ? 2'b10 : 2'b00), infl_last_q};
    // An empty FIFO forwards the in-flight SRAM word directly to R.
    if (nbuf_q != 2'd0) head = slot0_q;
    else if (infl_q)    head = in_entry;
    else                head = '0;
    s_rvalid = (nbuf_q != 2'd0) || infl_q;
    s_rdata  = head[DW+2:3];
    s_rresp  = head[2:1];
    s_rlast  = head[0];
    s_rid    = id_q;
    pop      = s_rvalid && s_rready;
    pop_buf  = pop && (nbuf_q != 2'd0);
    push     = infl_q && !(pop && (nbuf_q == 2'd0));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    id_d        = id_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    infl_d      = issue;
    infl_err_d  = beat_err;
    infl_last_d = (cnt_q == len_q);
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    nbuf_d      = nbuf_q;

    if (pop_buf) begin
      slot0_d = slot1_q;
      nbuf_d  = nbuf_d - 2'd1;
    end
    if (push) begin
      if (nbuf_d == 2'd0) slot0_d = in_entry;
      else                slot1_d = in_entry;
      nbuf_d = nbuf_d + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d  = s_araddr;
          id_d    = s_arid;
          len_d   = s_arlen;
          size_d  = s_arsize;
          burst_d = s_arburst;
          err_d   = ar_err;
          cnt_d   = 8'd0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (issue) begin
          addr_d = addr_next;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((nbuf_q == 2'd0) && !infl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      id_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_err_q  <= 1'b0;
      infl_last_q <= 1'b0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      nbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      infl_q      <= infl_d;
      infl_err_q  <= infl_err_d;
      infl_last_q <= infl_last_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      nbuf_q      <= nbuf_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_sram_responder.sv
// tb/tb_axi_rd_sram_responder.sv - directed self-checking bench for axi_rd_sram_responder.
module tb_axi_rd_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk_i, arst_i;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arid, s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [7:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        mem_ren;
  logic [11:0] mem_addr;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] b_data [256];
  logic [1:0]  b_resp [256];
  logic        b_last [256];
  logic [7:0]  b_id   [256];
  int          b_k    [256];
  int nb, ren_cnt, first_ren_k, stab_bad, ar_bad, idle_k;
  logic timeout;

  axi_rd_sram_responder dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] word(input logic [11:0] a);
    return {20'hDA7A0, a, 20'h55550, ~a};
  endfunction

  always @(posedge clk_i) if (mem_ren) mem_rdata <= word(mem_addr);

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int pat);
    int k, n;
    logic [63:0] pd;
    logic [1:0] pr;
    logic pl, stalled;
    nb = 0; ren_cnt = 0; first_ren_k = -1; stab_bad = 0; ar_bad = 0; idle_k = -1;
    timeout = 1'b0; stalled = 1'b0; pd = '0; pr = '0; pl = 1'b0;
    @(negedge clk_i);
    s_araddr = addr; s_arid = id; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge clk_i); n++; end
    if (!s_arready) timeout = 1'b1;
    @(negedge clk_i);
    s_arvalid = 1'b0; s_araddr = 32'hDEAD_BEEF; s_arlen = 8'hFF; s_arburst = 2'b00;
    k = 1;
    while (k < 4 * (len + 1) + 40) begin
      if (mem_ren) begin ren_cnt++; if (first_ren_k < 0) first_ren_k = k; end
      if (stalled && (!s_rvalid || s_rdata !== pd || s_rresp !== pr || s_rlast !== pl)) stab_bad++;
      if (nb < len + 1 && s_arready) ar_bad++;
      if (nb == len + 1 && s_arready) begin idle_k = k; break; end
      s_rready = (pat == 0) ? 1'b1 : ((k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5));
      if (s_rvalid && s_rready) begin
        if (nb < 256) begin
          b_data[nb] = s_rdata; b_resp[nb] = s_rresp; b_last[nb] = s_rlast;
          b_id[nb] = s_rid; b_k[nb] = k;
        end
        nb++;
        stalled = 1'b0;
      end else if (s_rvalid) begin
        stalled = 1'b1; pd = s_rdata; pr = s_rresp; pl = s_rlast;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk_i);
      k++;
    end
    if (idle_k < 0) timeout = 1'b1;
    s_rready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", s_arready); end
    checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", s_rvalid); end
    checks++; if ({s_rlast, s_rresp, s_rid} !== 11'd0) begin errors++; $display("FAIL rst_rmeta got %h want 0", {s_rlast, s_rresp, s_rid}); end
    checks++; if (s_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", s_rdata); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL rst_mem_ren got %b want 0", mem_ren); end
    arst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL rst_release_arready got %b want 1", s_arready); end
  endtask

  task automatic test_incr();
    run_burst(BASE + 32'h10, 8'h5A, 8'd3, 3'd3, 2'b01, 0);
    checks++; if (timeout !== 1'b0 || nb !== 4) begin errors++; $display("FAIL incr_count got %0d timeout %b want 4", nb, timeout); end
    checks++; if (first_ren_k !== 1) begin errors++; $display("FAIL incr_ren_latency got %0d want 1", first_ren_k); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_data[i] !== word(12'(2 + i))) begin errors++; $display("FAIL incr_data%0d got %h want %h", i, b_data[i], word(12'(2 + i))); end
      checks++; if (b_k[i] !== 2 + i) begin errors++; $display("FAIL incr_cycle%0d got %0d want %0d", i, b_k[i], 2 + i); end
      checks++; if ({b_last[i], b_resp[i], b_id[i]} !== {(i == 3), 2'b00, 8'h5A}) begin
        errors++; $display("FAIL incr_meta%0d got %h want %h", i, {b_last[i], b_resp[i], b_id[i]}, {(i == 3), 2'b00, 8'h5A}); end
    end
  endtask

  task automatic test_wrap();
    int exp_w [4] = '{3, 0, 1, 2};
    run_burst(BASE + 32'h18, 8'h21, 8'd3, 3'd3, 2'b10, 0);
    checks++; if (timeout !== 1'b0 || nb !== 4) begin errors++; $display("FAIL wrap_count got %0d want 4", nb); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_data[i] !== word(12'(exp_w[i])) || b_last[i] !== (i == 3) || b_resp[i] !== 2'b00) begin
        errors++; $display("FAIL wrap_beat%0d got %h/%b/%b want %h/%b/00", i, b_data[i], b_last[i], b_resp[i], word(12'(exp_w[i])), (i == 3)); end
    end
  endtask

  task automatic test_backpressure();
    run_burst(BASE + 32'h40, 8'h77, 8'd7, 3'd3, 2'b01, 1);
    checks++; if (timeout !== 1'b0 || nb !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", nb); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stab_bad); end
    checks++; if (ar_bad !== 0) begin errors++; $display("FAIL bp_arready got %0d early cycles want 0", ar_bad); end
    checks++; if (ren_cnt !== 8) begin errors++; $display("FAIL bp_ren_count got %0d want 8", ren_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (b_data[i] !== word(12'(8 + i)) || b_last[i] !== (i == 7)) begin
        errors++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, b_data[i], b_last[i], word(12'(8 + i)), (i == 7)); end
    end
  endtask

  task automatic test_errors();
    run_burst(BASE, 8'h03, 8'd1, 3'd4, 2'b01, 0);
    checks++; if (timeout !== 1'b0 || nb !== 2) begin errors++; $display("FAIL size_count got %0d want 2", nb); end
    checks++; if ({b_resp[0], b_resp[1]} !== 4'b1010 || b_data[0] !== 64'd0 || b_data[1] !== 64'd0) begin
      errors++; $display("FAIL size_resp got %b%b data %h %h want 1010 data 0", b_resp[0], b_resp[1], b_data[0], b_data[1]); end
    checks++; if ({b_last[0], b_last[1]} !== 2'b01) begin errors++; $display("FAIL size_last got %b%b want 01", b_last[0], b_last[1]); end
    run_burst(BASE, 8'h04, 8'd0, 3'd3, 2'b11, 0);
    checks++; if (timeout !== 1'b0 || nb !== 1 || b_resp[0] !== 2'b10 || b_last[0] !== 1'b1) begin
      errors++; $display("FAIL rsvd_burst got n=%0d resp=%b last=%b want n=1 resp=10 last=1", nb, b_resp[0], b_last[0]); end
    run_burst(BASE, 8'h05, 8'd2, 3'd3, 2'b10, 0);
    checks++; if (timeout !== 1'b0 || nb !== 3 || {b_resp[0], b_resp[1], b_resp[2]} !== 6'b101010 || b_last[2] !== 1'b1) begin
      errors++; $display("FAIL wrap_badlen got n=%0d resp=%b%b%b want n=3 resp=101010", nb, b_resp[0], b_resp[1], b_resp[2]); end
  endtask

  task automatic test_boundaries();
    int bad;
    run_burst(BASE + 32'h8, 8'h11, 8'd0, 3'd3, 2'b01, 0);
    checks++; if (timeout !== 1'b0 || nb !== 1 || b_data[0] !== word(12'd1) || b_last[0] !== 1'b1) begin
      errors++; $display("FAIL len0 got n=%0d data=%h last=%b want n=1 data=%h last=1", nb, b_data[0], b_last[0], word(12'd1)); end
    run_burst(BASE + 32'h20, 8'h12, 8'd2, 3'd3, 2'b00, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) if (b_data[i] !== word(12'd4)) bad++;
    checks++; if (timeout !== 1'b0 || nb !== 3 || bad !== 0 || b_last[2] !== 1'b1) begin
      errors++; $display("FAIL fixed got n=%0d bad=%0d want n=3 bad=0", nb, bad); end
    run_burst(BASE, 8'h13, 8'd255, 3'd3, 2'b01, 0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (b_data[i] !== word(12'(i)) || b_last[i] !== (i == 255) || b_resp[i] !== 2'b00) bad++;
    checks++; if (timeout !== 1'b0 || nb !== 256) begin errors++; $display("FAIL len255_count got %0d want 256", nb); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL len255_beats got %0d bad beats want 0", bad); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    s_araddr = BASE; s_arid = 8'h66; s_arlen = 8'd3; s_arsize = 3'd3; s_arburst = 2'b01;
    s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge clk_i);
    s_arvalid = 1'b0;
    @(negedge clk_i);
    checks++; if (s_rvalid !== 1'b1 || s_rdata !== word(12'd0)) begin errors++; $display("FAIL midrst_beat0 got %b/%h want 1/%h", s_rvalid, s_rdata, word(12'd0)); end
    @(negedge clk_i);
    @(negedge clk_i);
    arst_i = 1'b1;
    #1;
    checks++; if ({s_rvalid, s_arready, mem_ren, s_rlast} !== 4'b0000) begin
      errors++; $display("FAIL midrst_outputs got %b want 0000", {s_rvalid, s_arready, mem_ren, s_rlast}); end
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_release got ar=%b rv=%b want 1 0", s_arready, s_rvalid); end
    run_burst(BASE, 8'h67, 8'd0, 3'd3, 2'b01, 0);
    checks++; if (timeout !== 1'b0 || nb !== 1 || b_data[0] !== word(12'd0) || b_resp[0] !== 2'b00 || b_id[0] !== 8'h67) begin
      errors++; $display("FAIL midrst_next got n=%0d data=%h resp=%b id=%h want 1 %h 00 67", nb, b_data[0], b_resp[0], b_id[0], word(12'd0)); end
  endtask

  task automatic test_range();
    run_burst(BASE + 32'h8000, 8'h31, 8'd0, 3'd3, 2'b01, 0);
    checks++; if (timeout !== 1'b0 || nb !== 1) begin errors++; $display("FAIL range_count got %0d want 1", nb); end
`ifdef AXI_RD_RANGECHK_EN
    checks++; if (b_resp[0] !== 2'b10 || b_data[0] !== 64'd0) begin errors++; $display("FAIL range_resp got %b/%h want 10/0", b_resp[0], b_data[0]); end
    checks++; if (ren_cnt !== 0) begin errors++; $display("FAIL range_ren got %0d want 0", ren_cnt); end
`else
    checks++; if (b_resp[0] !== 2'b00 || b_data[0] !== word(12'd0)) begin errors++; $display("FAIL range_resp got %b/%h want 00/%h", b_resp[0], b_data[0], word(12'd0)); end
    checks++; if (ren_cnt !== 1) begin errors++; $display("FAIL range_ren got %0d want 1", ren_cnt); end
`endif
  endtask

  initial begin
    arst_i = 1'b1; s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; s_rready = 1'b1; mem_rdata = '0;
    repeat (2) @(negedge clk_i);
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_errors();
    test_boundaries();
    test_reset_mid();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
